decoder_scan_nbit: RTL and testbench

//  Registered N-to-2^N one-hot decoder with an auto-scan mode. Next-generation

---
 rtl/decoder_scan_nbit.sv | 135 +++++++++++++
 tb/tb_decoder_scan_nbit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_nbit.sv
// Registered N-to-2^N one-hot decoder with direct-decode and auto-scan modes.
// Optional one-cycle blank between scan steps: define DECODER_SCAN_BLANK_EN.
module decoder_scan_nbit #(
    parameter int N       = 3,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               mode,
    input  logic [N-1:0]       a,
    input  logic               start,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2**N-1:0]    y,
    output logic [N-1:0]       index,
    output logic               busy,
    output logic               wrap
);

    localparam int W = 2**N;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2,
        BLANK  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic [W-1:0]       y_nxt;
    logic [N-1:0]       index_nxt;
    logic [N-1:0]       index_inc;
    logic               busy_nxt;
    logic               wrap_nxt;
    logic               step;

    function automatic logic [W-1:0] onehot(input logic [N-1:0] sel);
        return {{(W-1){1'b0}}, 1'b1} << sel;
    endfunction

    // Natural N-bit rollover gives the 2^N-1 -> 0 wrap for free.
    assign index_inc = index + N'(1);
    // >= rather than == so that lowering dwell mid-step advances on the next edge.
    assign step      = (cnt >= dwell);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            y     <= '0;
            index <= '0;
            busy  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            y     <= y_nxt;
            index <= index_nxt;
            busy  <= busy_nxt;
            wrap  <= wrap_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else if (!mode) begin
            state_nxt = DIRECT;
        end else if (start) begin
            state_nxt = SCAN;
        end else begin
            case (state)
                SCAN: begin
`ifdef DECODER_SCAN_BLANK_EN
                    if (step) state_nxt = BLANK;
`else
                    state_nxt = SCAN;
`endif
                end
                BLANK:   state_nxt = SCAN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs; zero unless a branch drives them.
    always_comb begin
        y_nxt     = '0;
        index_nxt = '0;
        busy_nxt  = 1'b0;
        wrap_nxt  = 1'b0;
        cnt_nxt   = '0;
        if (enable) begin
            if (!mode) begin
                y_nxt     = onehot(a);
                index_nxt = a;
            end else if (start) begin
                y_nxt    = onehot(N'(0));
                busy_nxt = 1'b1;
            end else begin
                case (state)
                    SCAN: begin
                        busy_nxt = 1'b1;
                        if (!step) begin
                            y_nxt     = y;
                            index_nxt = index;
                            cnt_nxt   = cnt + DWELL_W'(1);
                        end else begin
`ifdef DECODER_SCAN_BLANK_EN
                            index_nxt = index;
`else
                            y_nxt     = onehot(index_inc);
                            index_nxt = index_inc;
                            wrap_nxt  = (index_inc == '0);
`endif
                        end
                    end
                    BLANK: begin
                        busy_nxt  = 1'b1;
                        y_nxt     = onehot(index_inc);
                        index_nxt = index_inc;
                        wrap_nxt  = (index_inc == '0);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decoder_scan_nbit.sv
// Directed-vector bench for decoder_scan_nbit (N=3, DWELL_W=4, default build without blank).
module tb_decoder_scan_nbit;

    localparam int N       = 3;
    localparam int DWELL_W = 4;

    logic               clk    = 1'b0;
    logic               rst    = 1'b0;
    logic               enable = 1'b0;
    logic               mode   = 1'b0;
    logic               start  = 1'b0;
    logic [N-1:0]       a      = '0;
    logic [DWELL_W-1:0] dwell  = '0;
    logic [7:0]         y;
    logic [N-1:0]       index;
    logic               busy;
    logic               wrap;

    int n_cmp = 0;
    int n_err = 0;

    decoder_scan_nbit #(.N(N), .DWELL_W(DWELL_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .mode   (mode),
        .a      (a),
        .start  (start),
        .dwell  (dwell),
        .y      (y),
        .index  (index),
        .busy   (busy),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] e;

        // Reset state, observed before any clock edge.
        #2 rst = 1'b1;
        #2;
        check("rst.y", y, 8'h00);
        check("rst.index", index, 0);
        check("rst.busy", busy, 0);
        check("rst.wrap", wrap, 0);
        tick(2);
        rst = 1'b0;

        // Direct decode, a=5, one-clock latency.
        enable = 1'b1;
        mode   = 1'b0;
        a      = 3'd5;
        tick();
        check("dir5.y", y, 8'b0010_0000);
        check("dir5.index", index, 5);
        check("dir5.busy", busy, 0);
        for (int i = 0; i < 8; i++) begin
            a = 3'(i);
            tick();
            e = 8'h01 << i;
            check($sformatf("dir_sweep%0d.y", i), y, e);
            check($sformatf("dir_sweep%0d.index", i), index, i);
        end
        enable = 1'b0;
        tick();
        check("dis.y", y, 8'h00);
        check("dis.index", index, 0);

        // mode=1 without start from DIRECT returns to idle with y=0.
        enable = 1'b1;
        tick();
        mode = 1'b1;
        tick();
        check("idle.y", y, 8'h00);
        check("idle.busy", busy, 0);

        // Scan dwell=2: each step lasts 3 cycles, wrap exactly at cycle 24.
        dwell = 4'd2;
        pulse_start();
        check("scan2.k0.y", y, 8'h01);
        check("scan2.k0.busy", busy, 1);
        check("scan2.k0.wrap", wrap, 0);
        for (int k = 1; k <= 24; k++) begin
            tick();
            e = 8'h01 << ((k / 3) % 8);
            check($sformatf("scan2.k%0d.y", k), y, e);
            check($sformatf("scan2.k%0d.wrap", k), wrap, (k == 24) ? 1 : 0);
            check($sformatf("scan2.k%0d.busy", k), busy, 1);
        end
        tick();
        check("scan2.after_wrap.wrap", wrap, 0);

        // dwell=0: shift every cycle, wrap every 8 cycles.
        dwell = 4'd0;
        pulse_start();
        for (int k = 1; k <= 16; k++) begin
            tick();
            e = 8'h01 << (k % 8);
            check($sformatf("scan0.k%0d.y", k), y, e);
            check($sformatf("scan0.k%0d.index", k), index, k % 8);
            check($sformatf("scan0.k%0d.wrap", k), wrap, (k % 8 == 0) ? 1 : 0);
            check($sformatf("scan0.k%0d.busy", k), busy, 1);
        end

        // Restart at index 5 mid-step: back to index 0 with a fresh count.
        dwell = 4'd3;
        pulse_start();
        tick(21);
        check("rs.pre.index", index, 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rs.y", y, 8'h01);
        check("rs.index", index, 0);
        check("rs.wrap", wrap, 0);
        check("rs.busy", busy, 1);
        tick(3);
        check("rs.hold.y", y, 8'h01);
        tick();
        check("rs.step.y", y, 8'h02);

        // start held high restarts every cycle.
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("hold%0d.y", k), y, 8'h01);
        end
        start = 1'b0;

        // Lowering dwell below the running count advances on the next edge.
        dwell = 4'd5;
        pulse_start();
        tick(3);
        check("live.pre.y", y, 8'h01);
        dwell = 4'd1;
        tick();
        check("live.y", y, 8'h02);

        // Leave scan via mode=0 at index 6.
        dwell = 4'd0;
        pulse_start();
        tick(6);
        check("m0.pre.index", index, 6);
        mode = 1'b0;
        a    = 3'd3;
        tick();
        check("m0.y", y, 8'h08);
        check("m0.index", index, 3);
        check("m0.busy", busy, 0);
        check("m0.wrap", wrap, 0);

        // enable=0 mid-scan clears everything on the next edge.
        mode = 1'b1;
        pulse_start();
        tick(3);
        enable = 1'b0;
        tick();
        check("en0.y", y, 8'h00);
        check("en0.busy", busy, 0);
        enable = 1'b1;

        // Asynchronous reset mid-scan, then idle until start.
        dwell = 4'd1;
        pulse_start();
        tick(5);
        check("ar.pre.y", y, 8'h04);
        #2 rst = 1'b1;
        #1;
        check("ar.y", y, 8'h00);
        check("ar.index", index, 0);
        check("ar.busy", busy, 0);
        check("ar.wrap", wrap, 0);
        #2 rst = 1'b0;
        tick(3);
        check("ar.idle.y", y, 8'h00);
        check("ar.idle.busy", busy, 0);
        pulse_start();
        check("ar.resume.y", y, 8'h01);
        check("ar.resume.busy", busy, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
